// File: rtl/lane_game_fd.sv
// Lane-dodging game datapath: one-hot player lane, scrolling obstacle/objective
// maps, collision with lives and invulnerability window, saturating score pickup.
module lane_game_fd #(
    parameter int LANES        = 4,
    parameter int ROWS         = 128,
    parameter int HIT_ROWS     = 24,
    parameter int LIVES        = 3,
    parameter int LW           = 2,
    parameter int SCORE_W      = 8,
    parameter int INVULN_MOVES = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    move_map,
    input  logic [LANES-1:0]        obstacle_row_in,
    input  logic [LANES-1:0]        objective_row_in,
    output logic [LANES-1:0]        player_pos,
    output logic [LW-1:0]           lives,
    output logic [SCORE_W-1:0]      score,
    output logic                    hit,
    output logic                    pickup,
    output logic                    invulnerable,
    output logic                    game_over,
    output logic [ROWS*LANES-1:0]   map_obstacles_flat,
    output logic [ROWS*LANES-1:0]   map_objectives_flat
);

    localparam int MW = ROWS * LANES;
    localparam int CW = $clog2(INVULN_MOVES + 1);
    localparam logic [LANES-1:0] POS_INIT = {1'b1, {(LANES-1){1'b0}}};

    logic            left_q, right_q;
    logic [CW-1:0]   inv_cnt;
    logic [MW-1:0]   obs_map, obj_map;
    logic [MW-1:0]   zone_mask;
    logic            obs_hit, obj_hit;
    logic            scroll, do_hit, do_pickup;
    logic            left_rise, right_rise;
    logic [LANES-1:0] pos_next;
    logic [MW-1:0]   obs_next, obj_next;

    // Zone mask: the player's lane replicated across the rows of the player zone.
    always_comb begin
        zone_mask = '0;
        for (int r = 0; r < HIT_ROWS; r++) begin
            zone_mask[r*LANES +: LANES] = player_pos;
        end
    end

    always_comb begin
        obs_hit    = |(obs_map & zone_mask);
        obj_hit    = |(obj_map & zone_mask);
        scroll     = move_map & ~game_over;
        do_hit     = obs_hit && (inv_cnt == '0) && !game_over;
        do_pickup  = obj_hit && !game_over && !move_map;
        left_rise  = btn_left & ~left_q;
        right_rise = btn_right & ~right_q;

        pos_next = player_pos;
        if (left_rise && !right_rise && !player_pos[LANES-1]) begin
            pos_next = player_pos << 1;
        end else if (right_rise && !left_rise && !player_pos[0]) begin
            pos_next = player_pos >> 1;
        end

        obs_next = obs_map;
        if (scroll) begin
            obs_next = {obstacle_row_in, obs_map[MW-1:LANES]};
        end

        // Pickup only happens on non-scroll cycles, so clear and shift never collide.
        obj_next = obj_map;
        if (do_pickup) begin
            obj_next = obj_map & ~zone_mask;
        end else if (scroll) begin
            obj_next = {objective_row_in, obj_map[MW-1:LANES]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            player_pos <= POS_INIT;
            lives      <= LW'(LIVES);
            score      <= '0;
            obs_map    <= '0;
            obj_map    <= '0;
            inv_cnt    <= '0;
            hit        <= 1'b0;
            pickup     <= 1'b0;
            game_over  <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
        end else if (start) begin
            player_pos <= POS_INIT;
            lives      <= LW'(LIVES);
            score      <= '0;
            obs_map    <= '0;
            obj_map    <= '0;
            inv_cnt    <= '0;
            hit        <= 1'b0;
            pickup     <= 1'b0;
            game_over  <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
        end else begin
            player_pos <= pos_next;
            left_q     <= btn_left;
            right_q    <= btn_right;
            obs_map    <= obs_next;
            obj_map    <= obj_next;
            hit        <= do_hit;
            pickup     <= do_pickup;

            // A fresh hit reloads the window and takes priority over a decrement.
            if (do_hit) begin
                lives   <= lives - LW'(1);
                inv_cnt <= CW'(INVULN_MOVES);
                if (lives == LW'(1)) begin
                    game_over <= 1'b1;
                end
            end else if (move_map && (inv_cnt != '0)) begin
                inv_cnt <= inv_cnt - CW'(1);
            end

            if (do_pickup && (score != '1)) begin
                score <= score + SCORE_W'(1);
            end
        end
    end

    assign invulnerable        = (inv_cnt != '0);
    assign map_obstacles_flat  = obs_map;
    assign map_objectives_flat = obj_map;

endmodule

// File: tb/tb_lane_game_fd.sv
// Self-checking bench for lane_game_fd: button table, directed scroll/collision/
// pickup/game-over sequences, then random stimulus against a row-array model.
module tb_lane_game_fd;

    localparam int LANES = 4;
    localparam int ROWS  = 32;
    localparam int HITR  = 2;
    localparam int NLIV  = 3;
    localparam int INV   = 4;
    localparam int SMAX  = 255;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, move_map = 1'b0;
    logic [3:0] obstacle_row_in = '0, objective_row_in = '0;
    logic [3:0]   player_pos;
    logic [1:0]   lives;
    logic [7:0]   score;
    logic         hit, pickup, invulnerable, game_over;
    logic [127:0] map_obstacles_flat, map_objectives_flat;

    lane_game_fd #(
        .LANES(4), .ROWS(32), .HIT_ROWS(2), .LIVES(3), .LW(2), .SCORE_W(8), .INVULN_MOVES(4)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .btn_left(btn_left), .btn_right(btn_right), .move_map(move_map),
        .obstacle_row_in(obstacle_row_in), .objective_row_in(objective_row_in),
        .player_pos(player_pos), .lives(lives), .score(score),
        .hit(hit), .pickup(pickup), .invulnerable(invulnerable), .game_over(game_over),
        .map_obstacles_flat(map_obstacles_flat), .map_objectives_flat(map_objectives_flat)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: lane index, integer counters, one array entry per map row.
    int         m_p, m_lives, m_score, m_cnt;
    bit         m_go, m_hit, m_pick, m_pl, m_pr;
    logic [3:0] m_obs[ROWS];
    logic [3:0] m_obj[ROWS];

    task automatic model_reset();
        m_p = LANES - 1; m_lives = NLIV; m_score = 0; m_cnt = 0;
        m_go = 0; m_hit = 0; m_pick = 0; m_pl = 0; m_pr = 0;
        for (int r = 0; r < ROWS; r++) begin
            m_obs[r] = '0;
            m_obj[r] = '0;
        end
    endtask

    task automatic model_step(input bit bl, input bit br, input bit mm, input bit st,
                              input logic [3:0] bi, input logic [3:0] oi);
        bit oh, jh, lr, rr, go0;
        int p0;
        if (st) begin
            model_reset();
        end else begin
            oh = 0; jh = 0;
            for (int r = 0; r < HITR; r++) begin
                if (m_obs[r][m_p]) oh = 1;
                if (m_obj[r][m_p]) jh = 1;
            end
            p0 = m_p; go0 = m_go;
            m_hit = 0; m_pick = 0;
            if (oh && m_cnt == 0 && !go0) begin
                m_lives--; m_hit = 1; m_cnt = INV;
                if (m_lives == 0) m_go = 1;
            end else if (mm && m_cnt > 0) begin
                m_cnt--;
            end
            if (jh && !go0 && !mm) begin
                if (m_score < SMAX) m_score++;
                m_pick = 1;
                for (int r = 0; r < HITR; r++) m_obj[r][p0] = 1'b0;
            end
            if (mm && !go0) begin
                for (int r = 0; r < ROWS - 1; r++) begin
                    m_obs[r] = m_obs[r+1];
                    m_obj[r] = m_obj[r+1];
                end
                m_obs[ROWS-1] = bi;
                m_obj[ROWS-1] = oi;
            end
            lr = bl && !m_pl;
            rr = br && !m_pr;
            if (lr && !rr && m_p < LANES - 1) m_p++;
            else if (rr && !lr && m_p > 0) m_p--;
            m_pl = bl; m_pr = br;
        end
    endtask

    task automatic check_model();
        logic [127:0] fo, fj;
        for (int r = 0; r < ROWS; r++) begin
            fo[r*4 +: 4] = m_obs[r];
            fj[r*4 +: 4] = m_obj[r];
        end
        chk("pos",   128'(player_pos),   128'(1 << m_p));
        chk("lives", 128'(lives),        128'(m_lives));
        chk("score", 128'(score),        128'(m_score));
        chk("hit",   128'(hit),          128'(m_hit));
        chk("pick",  128'(pickup),       128'(m_pick));
        chk("inv",   128'(invulnerable), 128'(m_cnt != 0));
        chk("go",    128'(game_over),    128'(m_go));
        chk("obs_map", map_obstacles_flat,  fo);
        chk("obj_map", map_objectives_flat, fj);
    endtask

    task automatic step(input bit bl, input bit br, input bit mm, input bit st,
                        input logic [3:0] bi, input logic [3:0] oi);
        btn_left = bl; btn_right = br; move_map = mm; start = st;
        obstacle_row_in = bi; objective_row_in = oi;
        model_step(bl, br, mm, st, bi, oi);
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic scroll(input logic [3:0] bi, input logic [3:0] oi);
        step(0, 0, 1, 0, bi, oi);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 4'b0, 4'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pos"},   128'(player_pos), 128'(4'b1000));
        chk({tag, "_lives"}, 128'(lives),      128'(3));
        chk({tag, "_score"}, 128'(score),      128'(0));
        chk({tag, "_obs"},   map_obstacles_flat,  128'(0));
        chk({tag, "_obj"},   map_objectives_flat, 128'(0));
        chk({tag, "_go"},    128'(game_over),  128'(0));
        chk({tag, "_hit"},   128'(hit),        128'(0));
        chk({tag, "_inv"},   128'(invulnerable), 128'(0));
    endtask

    typedef struct {
        bit         bl;
        bit         br;
        logic [3:0] exp_pos;
    } btn_vec_t;

    btn_vec_t btn_tbl[24];
    int hits_seen;
    logic [127:0] frz_o, frz_j;

    initial begin
        btn_tbl = '{
            '{1, 0, 4'b1000}, '{1, 0, 4'b1000}, '{1, 0, 4'b1000}, '{1, 0, 4'b1000},
            '{1, 0, 4'b1000}, '{1, 0, 4'b1000}, '{1, 0, 4'b1000}, '{1, 0, 4'b1000},
            '{1, 0, 4'b1000}, '{1, 0, 4'b1000}, '{0, 0, 4'b1000}, '{0, 1, 4'b0100},
            '{0, 0, 4'b0100}, '{0, 1, 4'b0010}, '{0, 0, 4'b0010}, '{0, 1, 4'b0001},
            '{0, 0, 4'b0001}, '{0, 1, 4'b0001}, '{0, 0, 4'b0001}, '{1, 0, 4'b0010},
            '{0, 0, 4'b0010}, '{1, 1, 4'b0010}, '{0, 0, 4'b0010}, '{1, 0, 4'b0100}
        };

        // Clock/reset
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        chk_reset_vals("rst");

        // Button table
        foreach (btn_tbl[i]) begin
            step(btn_tbl[i].bl, btn_tbl[i].br, 0, 0, 4'b0, 4'b0);
            chk($sformatf("btn_%0d", i), 128'(player_pos), 128'(btn_tbl[i].exp_pos));
        end

        // Scroll: obstacle in lane 1 travels the whole map (player is in lane 2)
        scroll(4'b0010, 4'b0);
        repeat (31) scroll(4'b0, 4'b0);
        chk("scroll_row0", 128'(map_obstacles_flat[3:0]), 128'(4'b0010));
        scroll(4'b0, 4'b0);
        chk("scroll_gone", map_obstacles_flat, 128'(0));

        // Collision in player lane 2, then invulnerability window
        scroll(4'b0100, 4'b0);
        repeat (30) scroll(4'b0, 4'b0);
        chk("col_row1", 128'(map_obstacles_flat[7:4]), 128'(4'b0100));
        idle();
        chk("col_hit", 128'(hit), 128'(1));
        chk("col_lives", 128'(lives), 128'(2));
        chk("col_inv", 128'(invulnerable), 128'(1));
        idle();
        chk("col_hit_once", 128'(hit), 128'(0));
        repeat (3) scroll(4'b0, 4'b0);
        chk("col_inv_3", 128'(invulnerable), 128'(1));
        chk("col_lives_held", 128'(lives), 128'(2));
        scroll(4'b0, 4'b0);
        chk("col_inv_end", 128'(invulnerable), 128'(0));

        // Pickup on a non-scroll cycle
        scroll(4'b0, 4'b0100);
        repeat (31) scroll(4'b0, 4'b0);
        idle();
        chk("pk_score", 128'(score), 128'(1));
        chk("pk_pulse", 128'(pickup), 128'(1));
        chk("pk_clear", map_objectives_flat, 128'(0));

        // Pickup deferred by a scroll
        scroll(4'b0, 4'b0100);
        repeat (30) scroll(4'b0, 4'b0);
        scroll(4'b0, 4'b0);
        chk("pkd_wait", 128'(pickup), 128'(0));
        chk("pkd_score0", 128'(score), 128'(1));
        idle();
        chk("pkd_pulse", 128'(pickup), 128'(1));
        chk("pkd_score", 128'(score), 128'(2));
        chk("pkd_clear", map_objectives_flat, 128'(0));

        // Saturating score
        for (int i = 0; i < 1200 && m_score < SMAX; i++) begin
            scroll(4'b0, 4'b0100);
            idle();
        end
        chk("sat_reached", 128'(score), 128'(SMAX));
        scroll(4'b0, 4'b0100);
        idle();
        chk("sat_hold", 128'(score), 128'(SMAX));
        chk("sat_pulse", 128'(pickup), 128'(1));

        // Game over: three separated obstacles in lane 3
        step(0, 0, 0, 1, 4'b0, 4'b0);
        chk_reset_vals("start1");
        hits_seen = 0;
        for (int i = 0; i < 60; i++) begin
            scroll((i == 0 || i == 8 || i == 16) ? 4'b1000 : 4'b0000, 4'b0);
            if (hit) begin
                hits_seen++;
                if (hits_seen == 3) chk("go_on_3rd", 128'(game_over), 128'(1));
            end
        end
        chk("go_hits", 128'(hits_seen), 128'(3));
        chk("go_lives", 128'(lives), 128'(0));
        chk("go_flag", 128'(game_over), 128'(1));
        scroll(4'b1111, 4'b0110);
        frz_o = map_obstacles_flat;
        frz_j = map_objectives_flat;
        repeat (5) scroll(4'b1111, 4'b1111);
        chk("go_frz_obs", map_obstacles_flat, frz_o);
        chk("go_frz_obj", map_objectives_flat, frz_j);
        chk("go_stays", 128'(game_over), 128'(1));
        step(0, 0, 0, 1, 4'b0, 4'b0);
        chk_reset_vals("start2");

        // Random stimulus against the model, with an asynchronous reset mid-run
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 reset = 1'b1;
                #1 chk_reset_vals("areset");
                @(posedge clock);
                #1 reset = 1'b0;
                model_reset();
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 499) == 0,
                 ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lane_game_fd.md
# lane_game_fd

Parametrised datapath for lane-dodging games. It holds a player one-hot lane position, a scrolling obstacle/objective map fed row-by-row from an external generator, collision handling with a life counter and invulnerability window, objective pickup with saturating score, and a latched game-over flag. It sits under the game control unit, which issues `move_map` pulses and `start`. It replaces fixed 4-lane, single-life datapaths.

## Interface
- `LANES`, 4, number of lanes (≥2); player position width
- `ROWS`, 128, map depth in rows; row 0 is nearest the player
- `HIT_ROWS`, 24, rows 0..HIT_ROWS-1 form the player zone (1 ≤ HIT_ROWS ≤ ROWS)
- `LIVES`, 3, initial life count (≥1)
- `LW`, 2, lives width (2^LW > LIVES)
- `SCORE_W`, 8, score width
- `INVULN_MOVES`, 24, map moves of invulnerability after a hit (≥1)

- `clock` in 1: system clock
- `reset` in 1: asynchronous, active-high; clock `clock`
- `start` in 1: synchronous clear to reset state
- `btn_left` in 1: level button; move toward MSB
- `btn_right` in 1: level button; move toward LSB
- `move_map` in 1: one-cycle scroll pulse
- `obstacle_row_in` in LANES: row entering at ROWS-1 on scroll
- `objective_row_in` in LANES: row entering at ROWS-1 on scroll
- `player_pos` out LANES: one-hot lane
- `lives` out LW: remaining lives
- `score` out SCORE_W: collected objectives, saturating
- `hit` out 1: one-cycle pulse on life loss
- `pickup` out 1: one-cycle pulse on score increment
- `invulnerable` out 1: invulnerability counter nonzero
- `game_over` out 1: latched when lives reach 0
- `map_obstacles_flat` out ROWS*LANES: row r at bits [r*LANES +: LANES]
- `map_objectives_flat` out ROWS*LANES: same layout

## Operation
- Reset/`start` values: player_pos = 1<<(LANES-1); lives = LIVES; score = 0; both maps 0; invuln counter 0; hit, pickup, game_over = 0; button history 0. `reset` wins over `start`; `start` wins over all other inputs.
- Buttons: internal registered history per button; a rise = current 1, previous 0. Left rise with position ≠ MSB: shift left. Right rise with position ≠ LSB: shift right. Both rises same cycle: no move. Moves are allowed during game_over.
- Scroll (`move_map`=1, game_over=0): every row r<ROWS-1 takes row r+1; row ROWS-1 takes `*_row_in`; row 0 content is discarded. While game_over=1, maps freeze.
- Zone hits: `obs_hit` = OR over r<HIT_ROWS of (obstacle row r & player_pos); `obj_hit` likewise on objectives; both from current registered state.
- Hit: if obs_hit && counter=0 && !game_over: lives−1, `hit`=1 one cycle, counter loaded with INVULN_MOVES. If lives was 1, game_over sets on the same edge.
- Invuln counter decrements by 1 on each `move_map` while nonzero (including the load cycle's following scrolls only; a load beats a decrement on the same edge).
- Pickup: if obj_hit && !game_over && `move_map`=0: score+1 (holds at 2^SCORE_W−1 but `pickup` still pulses), and every objective bit in the player's lane within rows 0..HIT_ROWS-1 clears. If `move_map`=1 that cycle, pickup defers to the next cycle with the shifted map.
- Hit and pickup in the same cycle are both processed.

## Timing
- Position, lives, score, maps, flags all update on the rising edge where the condition is sampled; `hit`/`pickup` are high for exactly that following cycle.
- Button to position: one edge from the first sample of 1 after a 0.
- Scroll to zone effect: new map visible the cycle after `move_map`; collision reacts one edge later.
- game_over stays 1 until `reset` or `start`; asynchronous `reset` mid-game forces all reset values immediately.

## Test plan
- LANES=4, ROWS=32, HIT_ROWS=2, LIVES=3, INVULN_MOVES=4 for all cases.
- Reset: after release, player_pos=4'b1000, lives=3, score=0, maps all 0, game_over=0; btn_left held 10 cycles → position stays 1000; btn_right pulse ×3 → 0100, 0010, 0001; fourth → 0001; both rising together → no move.
- Scroll: feed obstacle_row_in=4'b0010 on one move_map then zeros; after 31 further scrolls row 0 = 0010; after 32 scrolls bit gone.
- Collision: obstacle reaches row 1 in player lane → hit pulse, lives 3→2, invulnerable=1; stays in lane 2 more scrolls → no further hit; after 4 scrolls invulnerable=0.
- Pickup: objective in player lane at row 0 with move_map=0 → score 0→1, pickup pulse, bit cleared; same with move_map=1 that cycle → pickup one cycle later. Score at 255 + pickup → stays 255.
- Game over: three separated hits → lives 0, game_over=1 on third hit edge; further scrolls leave maps unchanged; `start` → all reset values.
